// File: rtl/frame_buffer_reader_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | frame_buffer_reader_pkg                                            |
// | VGA 640x480 timing constants, frame geometry and RGB444 packing   |
// | shared by the frame-buffer reader and the camera writer.           |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package frame_buffer_reader_pkg;

   localparam int FRAME_WIDTH      = 640;
   localparam int FRAME_HEIGHT     = 480;
   localparam int PIXEL_W          = 12;
   localparam int ADDR_W           = 19;
   localparam int CNT_W            = 10;

   localparam int VGA_H_TOTAL      = 800;
   localparam int VGA_V_TOTAL      = 525;
   localparam int VGA_H_SYNC_START = 656;
   localparam int VGA_H_SYNC_END   = 752;
   localparam int VGA_V_SYNC_START = 490;
   localparam int VGA_V_SYNC_END   = 492;

   // Per-pixel control bits that must travel alongside the BRAM read.
   typedef struct packed {
      logic active;
      logic hs;
      logic vs;
   } pix_ctl_t;

   // Linear frame-buffer address, evaluated entirely at address width.
   function automatic logic [ADDR_W-1:0] pixel_addr(
      input logic [CNT_W-1:0]  h,
      input logic [CNT_W-1:0]  v,
      input logic [ADDR_W-1:0] width
   );
      return ADDR_W'(h) + ADDR_W'(v) * width;
   endfunction

endpackage
`default_nettype wire

// File: rtl/frame_buffer_reader_timing.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_timing_640x480                                                 |
// | Pixel/line counters with active, sync and frame-start decode.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module vga_timing_640x480
   import frame_buffer_reader_pkg::*;
#(
   parameter int HCOUNT_MAX   = FRAME_WIDTH - 1,
   parameter int VCOUNT_MAX   = FRAME_HEIGHT - 1,
   parameter int H_TOTAL      = VGA_H_TOTAL,
   parameter int V_TOTAL      = VGA_V_TOTAL,
   parameter int H_SYNC_START = VGA_H_SYNC_START,
   parameter int H_SYNC_END   = VGA_H_SYNC_END,
   parameter int V_SYNC_START = VGA_V_SYNC_START,
   parameter int V_SYNC_END   = VGA_V_SYNC_END
)(
   input  logic             vga_clk,
   input  logic             reset,
   output logic [CNT_W-1:0] hcount,
   output logic [CNT_W-1:0] vcount,
   output logic             active,
   output logic             hs_raw,
   output logic             vs_raw,
   output logic             frame_start
);

   localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT_LAST = CNT_W'(HCOUNT_MAX);
   localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(VCOUNT_MAX);
   localparam logic [CNT_W-1:0] H_SS       = CNT_W'(H_SYNC_START);
   localparam logic [CNT_W-1:0] H_SE       = CNT_W'(H_SYNC_END);
   localparam logic [CNT_W-1:0] V_SS       = CNT_W'(V_SYNC_START);
   localparam logic [CNT_W-1:0] V_SE       = CNT_W'(V_SYNC_END);

   // Raster counters; line and frame wrap coincide at the last pixel.
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         hcount <= '0;
         vcount <= '0;
      end else if (hcount == H_LAST) begin
         hcount <= '0;
         vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
      end else begin
         hcount <= hcount + 1'b1;
      end
   end

   assign active = (hcount <= H_ACT_LAST) && (vcount <= V_ACT_LAST);
   assign hs_raw = (hcount >= H_SS) && (hcount < H_SE);
   assign vs_raw = (vcount >= V_SS) && (vcount < V_SE);

   // Counters sit at (0,0) during reset, so the pulse is held off until
   // reset is released; the first pulse then lands on the first free cycle.
   assign frame_start = ~reset && (hcount == '0) && (vcount == '0);

endmodule
`default_nettype wire

// File: rtl/frame_buffer_reader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | frame_buffer_reader                                                |
// | Reads RGB444 pixels from the frame BRAM in VGA raster order and    |
// | drives pixel-aligned colour and sync, gated per whole frame.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module frame_buffer_reader
   import frame_buffer_reader_pkg::*;
#(
   parameter int HCOUNT_MAX   = FRAME_WIDTH - 1,
   parameter int VCOUNT_MAX   = FRAME_HEIGHT - 1,
   parameter int H_TOTAL      = VGA_H_TOTAL,
   parameter int V_TOTAL      = VGA_V_TOTAL,
   parameter int H_SYNC_START = VGA_H_SYNC_START,
   parameter int H_SYNC_END   = VGA_H_SYNC_END,
   parameter int V_SYNC_START = VGA_V_SYNC_START,
   parameter int V_SYNC_END   = VGA_V_SYNC_END,
   parameter int BRAM_LATENCY = 2
)(
   input  logic               vga_clk,
   input  logic               reset,
   input  logic               display_enable,
   input  logic [PIXEL_W-1:0] memory_data,
   output logic [ADDR_W-1:0]  memory_addr,
   output logic [3:0]         vga_r,
   output logic [3:0]         vga_g,
   output logic [3:0]         vga_b,
   output logic               vga_hs,
   output logic               vga_vs,
   output logic               frame_start
);

   // Address register + BRAM latency; the colour/sync output register
   // adds the final stage, giving BRAM_LATENCY + 2 cycles end to end.
   localparam int               STAGES     = BRAM_LATENCY + 1;
   localparam logic [ADDR_W-1:0] LINE_WIDTH = ADDR_W'(HCOUNT_MAX + 1);

   logic [CNT_W-1:0] hcount;
   logic [CNT_W-1:0] vcount;
   logic             active;
   logic             hs_raw;
   logic             vs_raw;
   logic             enable_latched;
   pix_ctl_t         ctl_now;
   pix_ctl_t         ctl_out;
   pix_ctl_t         ctl_pipe [STAGES];

   vga_timing_640x480 #(
      .HCOUNT_MAX   (HCOUNT_MAX),
      .VCOUNT_MAX   (VCOUNT_MAX),
      .H_TOTAL      (H_TOTAL),
      .V_TOTAL      (V_TOTAL),
      .H_SYNC_START (H_SYNC_START),
      .H_SYNC_END   (H_SYNC_END),
      .V_SYNC_START (V_SYNC_START),
      .V_SYNC_END   (V_SYNC_END)
   ) u_timing (
      .vga_clk     (vga_clk),
      .reset       (reset),
      .hcount      (hcount),
      .vcount      (vcount),
      .active      (active),
      .hs_raw      (hs_raw),
      .vs_raw      (vs_raw),
      .frame_start (frame_start)
   );

   assign ctl_now = {active, hs_raw, vs_raw};
   assign ctl_out = ctl_pipe[STAGES-1];

   // Issue the BRAM read for the current raster position; park at 0 in blanking.
   always_ff @(posedge vga_clk) begin
      if (reset)
         memory_addr <= '0;
      else
         memory_addr <= active ? pixel_addr(hcount, vcount, LINE_WIDTH) : '0;
   end

   // Capture the display request only at frame start so a frame is never torn.
   always_ff @(posedge vga_clk) begin
      if (reset)
         enable_latched <= 1'b0;
      else if (frame_start)
         enable_latched <= display_enable;
   end

   // Delay active/sync so they meet the matching BRAM data; cleared on reset
   // so nothing stale leaves the pipeline after release.
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         for (int i = 0; i < STAGES; i++)
            ctl_pipe[i] <= '0;
      end else begin
         ctl_pipe[0] <= ctl_now;
         for (int i = 1; i < STAGES; i++)
            ctl_pipe[i] <= ctl_pipe[i-1];
      end
   end

   // Register colour (blanked outside the picture) and active-low sync.
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         {vga_r, vga_g, vga_b} <= '0;
         vga_hs                <= 1'b1;
         vga_vs                <= 1'b1;
      end else begin
         {vga_r, vga_g, vga_b} <= (ctl_out.active && enable_latched) ? memory_data : '0;
         vga_hs                <= ~ctl_out.hs;
         vga_vs                <= ~ctl_out.vs;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer_reader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_frame_buffer_reader                                             |
// | Directed bench: full-size instance for VGA timing/addressing, two  |
// | reduced-raster instances (BRAM latency 2 and 1) for frame-level    |
// | enable, sync counts and mid-frame reset.                           |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_frame_buffer_reader;

   // Reduced raster: 16x10 visible, 24x14 total.
   localparam int SH = 24;
   localparam int SV = 14;
   localparam int SF = SH * SV;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   logic display_enable;

   int n_assert = 0;
   int n_fail   = 0;
   int run      = 0;
   logic [3:0] en_tab = 4'b1101;

   logic [11:0] f_data, s2_data, s1_data;
   logic [18:0] f_addr, s2_addr, s1_addr;
   logic [3:0]  f_r, f_g, f_b, s2_r, s2_g, s2_b, s1_r, s1_g, s1_b;
   logic        f_hs, f_vs, f_fs, s2_hs, s2_vs, s2_fs, s1_hs, s1_vs, s1_fs;
   logic [11:0] f_b1, f_b2, s2_b1, s2_b2, s1_b1;

   frame_buffer_reader u_full (
      .vga_clk(clk), .reset(reset), .display_enable(display_enable),
      .memory_data(f_data), .memory_addr(f_addr),
      .vga_r(f_r), .vga_g(f_g), .vga_b(f_b),
      .vga_hs(f_hs), .vga_vs(f_vs), .frame_start(f_fs)
   );

   frame_buffer_reader #(
      .HCOUNT_MAX(15), .VCOUNT_MAX(9), .H_TOTAL(SH), .V_TOTAL(SV),
      .H_SYNC_START(18), .H_SYNC_END(21), .V_SYNC_START(11), .V_SYNC_END(13),
      .BRAM_LATENCY(2)
   ) u_s2 (
      .vga_clk(clk), .reset(reset), .display_enable(display_enable),
      .memory_data(s2_data), .memory_addr(s2_addr),
      .vga_r(s2_r), .vga_g(s2_g), .vga_b(s2_b),
      .vga_hs(s2_hs), .vga_vs(s2_vs), .frame_start(s2_fs)
   );

   frame_buffer_reader #(
      .HCOUNT_MAX(15), .VCOUNT_MAX(9), .H_TOTAL(SH), .V_TOTAL(SV),
      .H_SYNC_START(18), .H_SYNC_END(21), .V_SYNC_START(11), .V_SYNC_END(13),
      .BRAM_LATENCY(1)
   ) u_s1 (
      .vga_clk(clk), .reset(reset), .display_enable(display_enable),
      .memory_data(s1_data), .memory_addr(s1_addr),
      .vga_r(s1_r), .vga_g(s1_g), .vga_b(s1_b),
      .vga_hs(s1_hs), .vga_vs(s1_vs), .frame_start(s1_fs)
   );

   // BRAM content: low address bits with the top bit forced so every pixel is nonzero.
   function automatic logic [11:0] bram_f(input logic [18:0] a);
      return {1'b1, a[10:0]};
   endfunction

   // BRAM models, latency 2, 2 and 1.
   always @(posedge clk) begin
      f_b1  <= bram_f(f_addr);
      f_b2  <= f_b1;
      s2_b1 <= bram_f(s2_addr);
      s2_b2 <= s2_b1;
      s1_b1 <= bram_f(s1_addr);
   end
   assign f_data  = f_b2;
   assign s2_data = s2_b2;
   assign s1_data = s1_b1;

   function automatic logic [18:0] s_addr(input int m);
      int h;
      int v;
      h = m % SH;
      v = (m / SH) % SV;
      return (h <= 15 && v <= 9) ? 19'(h + v * 16) : 19'd0;
   endfunction

   function automatic logic en_of(input int m);
      return (run == 0) ? en_tab[m / SF] : 1'b1;
   endfunction

   task automatic chk(input string tag, input int n, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, n, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic chk_reset(input string nm, input int n, input logic [18:0] addr,
                            input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                            input logic hs, input logic vs, input logic fs, input logic fs_exp);
      chk({nm, " rst rgb"}, n, {r, g, b}, 12'h000);
      chk({nm, " rst hs"},  n, hs, 1'b1);
      chk({nm, " rst vs"},  n, vs, 1'b1);
      chk({nm, " rst addr"}, n, addr, 19'd0);
      chk({nm, " rst fs"},  n, fs, fs_exp);
   endtask

   // Expected outputs of a reduced-raster instance n cycles after reset release.
   task automatic chk_small(input string nm, input int n, input int d, input logic [18:0] addr,
                            input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                            input logic hs, input logic vs, input logic fs);
      int m;
      logic [11:0] e_rgb;
      logic e_hs;
      logic e_vs;
      m = n - d;
      e_rgb = 12'h000;
      e_hs = 1'b1;
      e_vs = 1'b1;
      if (m >= 0) begin
         int h;
         int v;
         h = m % SH;
         v = (m / SH) % SV;
         if (h <= 15 && v <= 9 && en_of(m)) e_rgb = bram_f(s_addr(m));
         e_hs = !(h >= 18 && h < 21);
         e_vs = !(v >= 11 && v < 13);
      end
      chk({nm, " rgb"}, n, {r, g, b}, e_rgb);
      chk({nm, " hs"}, n, hs, e_hs);
      chk({nm, " vs"}, n, vs, e_vs);
      chk({nm, " addr"}, n, addr, (n == 0) ? 19'd0 : s_addr(n - 1));
      chk({nm, " fs"}, n, fs, (n % SF) == 0);
   endtask

   int f_hs_low  = 0;
   int s2_hs_low = 0;
   int s2_vs_low = 0;
   int s2_fs_cnt = 0;

   initial begin
      reset = 1'b1;
      display_enable = 1'b0;
      repeat (3) step();
      chk_reset("full", -1, f_addr, f_r, f_g, f_b, f_hs, f_vs, f_fs, 1'b0);
      chk_reset("s2", -1, s2_addr, s2_r, s2_g, s2_b, s2_hs, s2_vs, s2_fs, 1'b0);
      chk_reset("s1", -1, s1_addr, s1_r, s1_g, s1_b, s1_hs, s1_vs, s1_fs, 1'b0);

      // Release: cycle 0 has counters at (0,0).
      reset = 1'b0;
      display_enable = 1'b1;
      #1;
      chk_reset("full", 0, f_addr, f_r, f_g, f_b, f_hs, f_vs, f_fs, 1'b1);
      chk_small("s2", 0, 4, s2_addr, s2_r, s2_g, s2_b, s2_hs, s2_vs, s2_fs);
      chk_small("s1", 0, 3, s1_addr, s1_r, s1_g, s1_b, s1_hs, s1_vs, s1_fs);
      s2_fs_cnt = 1;
      if (f_hs == 1'b0) f_hs_low++;

      for (int n = 1; n <= 1136; n++) begin
         step();
         chk_small("s2", n, 4, s2_addr, s2_r, s2_g, s2_b, s2_hs, s2_vs, s2_fs);
         chk_small("s1", n, 3, s1_addr, s1_r, s1_g, s1_b, s1_hs, s1_vs, s1_fs);
         if (n < 800 && f_hs == 1'b0) f_hs_low++;
         if (n >= 4 && n < 4 + SF && s2_hs == 1'b0) s2_hs_low++;
         if (n >= 4 + SF && n < 4 + 2 * SF && s2_vs == 1'b0) s2_vs_low++;
         if (s2_fs) s2_fs_cnt++;
         case (n)
            2:    chk("s1 black before first pixel", n, s1_r | s1_g | s1_b, 4'h0);
            3:    begin
                     chk("s2 black before first pixel", n, s2_r | s2_g | s2_b, 4'h0);
                     chk("s1 first pixel nonzero", n, ({s1_r, s1_g, s1_b} != 12'h0), 1'b1);
                     chk("full black before first pixel", n, {f_r, f_g, f_b}, 12'h000);
                  end
            4:    begin
                     chk("s2 first pixel nonzero", n, ({s2_r, s2_g, s2_b} != 12'h0), 1'b1);
                     chk("full pixel (0,0)", n, {f_r, f_g, f_b}, 12'h800);
                  end
            19:   chk("s2 last pixel nonzero", n, ({s2_r, s2_g, s2_b} != 12'h0), 1'b1);
            20:   chk("s2 black after line", n, {s2_r, s2_g, s2_b}, 12'h000);
            640:  chk("full addr (639,0)", n, f_addr, 19'd639);
            643:  chk("full pixel (639,0)", n, {f_r, f_g, f_b}, 12'hA7F);
            644:  chk("full black at h=640", n, {f_r, f_g, f_b}, 12'h000);
            659:  chk("full hs before sync", n, f_hs, 1'b1);
            660:  chk("full hs sync start", n, f_hs, 1'b0);
            700:  chk("full addr blanking", n, f_addr, 19'd0);
            755:  chk("full hs sync last", n, f_hs, 1'b0);
            756:  chk("full hs sync end", n, f_hs, 1'b1);
            799:  chk("full hs low count", n, f_hs_low, 96);
            801:  chk("full addr (0,1)", n, f_addr, 19'd640);
            803:  chk("full black end of line", n, {f_r, f_g, f_b}, 12'h000);
            804:  chk("full pixel (0,1)", n, {f_r, f_g, f_b}, 12'hA80);
            1000: begin
                     chk("full vs idle", n, f_vs, 1'b1);
                     chk("full fs idle", n, f_fs, 1'b0);
                     chk("s2 hs low count", n, s2_hs_low, 42);
                     chk("s2 vs low count", n, s2_vs_low, 48);
                  end
            1135: chk("s2 frame_start count", n, s2_fs_cnt, 4);
            default: ;
         endcase
         if (n == 120)  display_enable = 1'b0;
         if (n == 408)  display_enable = 1'b1;
         if (n == 1136) reset = 1'b1;
      end

      // Mid-frame reset held for three edges.
      for (int k = 0; k < 2; k++) begin
         step();
         chk_reset("full", 2000 + k, f_addr, f_r, f_g, f_b, f_hs, f_vs, f_fs, 1'b0);
         chk_reset("s2", 2000 + k, s2_addr, s2_r, s2_g, s2_b, s2_hs, s2_vs, s2_fs, 1'b0);
         chk_reset("s1", 2000 + k, s1_addr, s1_r, s1_g, s1_b, s1_hs, s1_vs, s1_fs, 1'b0);
      end
      step();
      reset = 1'b0;
      run = 1;
      #1;
      chk_reset("full restart", 0, f_addr, f_r, f_g, f_b, f_hs, f_vs, f_fs, 1'b1);
      chk_small("s2 restart", 0, 4, s2_addr, s2_r, s2_g, s2_b, s2_hs, s2_vs, s2_fs);
      chk_small("s1 restart", 0, 3, s1_addr, s1_r, s1_g, s1_b, s1_hs, s1_vs, s1_fs);
      for (int n = 1; n <= 40; n++) begin
         step();
         chk_small("s2 restart", n, 4, s2_addr, s2_r, s2_g, s2_b, s2_hs, s2_vs, s2_fs);
         chk_small("s1 restart", n, 3, s1_addr, s1_r, s1_g, s1_b, s1_hs, s1_vs, s1_fs);
         if (n <= 3) chk("full post-reset rgb", n, {f_r, f_g, f_b}, 12'h000);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
